module_join_collector: RTL and testbench
========================================

// Module: module_join_collector
// PURPOSE
//  Receiving end of the fork/join nibble-write protocol: collects two independently completing
//  branch results (lo half, hi half), arriving in any order, and joins them into one word.
//  Emits the word on a valid/ready output once both halves are held. Abandons a partial join
//  after a bounded wait. Sits downstream of fork-style producers, ahead of the result consumer.
// PARAMETERS
//  HALF_W   4    width of each branch payload; result width is 2*HALF_W
//  TIMEOUT  16   cycles to wait for the second branch after the first; 0 disables timeout
// PORTS
//  in_jc_clk       in   1         clock, all logic on posedge
//  in_jc_rst       in   1         reset, synchronous, active-high
//  in_jc_lo_valid  in   1         lo branch payload valid
//  in_jc_lo_data   in   HALF_W    lo branch payload
//  out_jc_lo_ready out  1         lo branch slot can accept
//  in_jc_hi_valid  in   1         hi branch payload valid
//  in_jc_hi_data   in   HALF_W    hi branch payload
//  out_jc_hi_ready out  1         hi branch slot can accept
//  out_jc_valid    out  1         joined result valid
//  out_jc_result   out  2*HALF_W  joined result {hi, lo}
//  in_jc_ready     in   1         consumer accepts result
//  out_jc_timeout  out  1         one-cycle pulse: partial join discarded
//  out_jc_count    out  8         joins delivered, wraps 255->0
// BEHAVIOUR
//  - Reset: state IDLE, both slots empty, out_jc_valid=0, out_jc_result=0, out_jc_timeout=0,
//    out_jc_count=0, wait counter=0; lo/hi ready=1 the cycle after reset deasserts.
//  - Reset mid-join or with result pending: held data dropped, no pulse, count cleared.
//  - Branch handshake: accept when valid && ready; out_jc_<x>_ready = !slot_<x>_full (registered flag).
//  - States: IDLE (no slot), WAIT_HI (lo held), WAIT_LO (hi held), FULL (both held, out valid).
//    IDLE: lo only -> WAIT_HI; hi only -> WAIT_LO; both same cycle -> FULL.
//    WAIT_x: missing branch accepted -> FULL; expiry -> IDLE.
//    FULL: in_jc_ready -> IDLE (slots cleared, count+1); else hold, output stable.
//  - Latency: last branch accepted in cycle N -> out_jc_valid=1 in N+1; result registered.
//  - No branch accepted in FULL (both readys 0); a new join starts the cycle after handoff.
//  - Wait counter: cleared on entering WAIT_x, +1 per cycle in WAIT_x. Expiry when counter
//    == TIMEOUT-1 and the missing branch is not accepted that cycle; arrival on the expiry
//    cycle wins (-> FULL). Expiry: slot cleared, out_jc_timeout=1 next cycle for one cycle.
//  - TIMEOUT=0: WAIT_x holds indefinitely, out_jc_timeout never asserts.
//  - Repeat arrivals of the held branch are back-pressured (ready=0); never overwrite.
//  - out_jc_result changes only on entry to FULL; it holds its last value while out_jc_valid=0.
// STRUCTURE
//  - Package module_join_collector_pkg: jc_state_e enum {IDLE, WAIT_LO, WAIT_HI, FULL},
//    default HALF_W/TIMEOUT localparams, COUNT_W=8.
//  - Sub-module join_branch_slot (data reg + full flag + ready), instantiated for lo and hi;
//    top holds FSM, wait counter, output register, join counter.
// TESTING
//  - Lo=4'hF cyc 1, hi=4'hA cyc 3, ready=1 -> valid cyc 4, result 8'hAF, count=1, IDLE cyc 5.
//  - Lo=4'h3, hi=4'hC same cycle N -> valid N+1 with 8'hC3; both branch readys 0 while FULL.
//  - FULL with in_jc_ready=0 for 5 cycles, lo_valid held 1 -> result stable, lo_ready 0, no accept.
//  - TIMEOUT=16: hi=4'h5 then no lo -> timeout pulse exactly one cycle, then IDLE, count unchanged;
//    lo on the expiry cycle instead -> FULL, no pulse.
//  - Reset asserted in WAIT_HI and in FULL -> all outputs 0 next cycle, readys 1 after release.
//  - 256 back-to-back joins -> out_jc_count wraps to 0; TIMEOUT=0 wait 1000 cycles -> no pulse.

Source files
------------

// File: rtl/module_join_collector_pkg.sv
// Shared definitions for the fork/join nibble collector.
//   jc_state_e     : join FSM states
//   DEF_HALF_W     : default branch payload width
//   DEF_TIMEOUT    : default wait budget for the second branch (0 = wait forever)
//   COUNT_W        : width of the delivered-join counter
//   wait_cnt_width : width needed for the wait counter of a given TIMEOUT
package module_join_collector_pkg;

    localparam int DEF_HALF_W  = 4;
    localparam int DEF_TIMEOUT = 16;
    localparam int COUNT_W     = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2,
        FULL    = 2'd3
    } jc_state_e;

    // The counter only has to reach TIMEOUT-1; keep at least one bit so a
    // zero or one TIMEOUT still yields a legal vector.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/module_join_collector_if.sv
// Handshake bundle between the two branch producers, the collector and the
// result consumer.
//   lo/hi branch : in_jc_<x>_valid, in_jc_<x>_data, out_jc_<x>_ready
//   result       : out_jc_valid, out_jc_result {hi, lo}, in_jc_ready
//   status       : out_jc_timeout (one-cycle discard pulse), out_jc_count
// slave  : the collector side
// master : the producer/consumer side
interface module_join_collector_if #(
    parameter int HALF_W = 4
);
    import module_join_collector_pkg::*;

    logic                  in_jc_lo_valid;
    logic [HALF_W-1:0]     in_jc_lo_data;
    logic                  out_jc_lo_ready;
    logic                  in_jc_hi_valid;
    logic [HALF_W-1:0]     in_jc_hi_data;
    logic                  out_jc_hi_ready;
    logic                  out_jc_valid;
    logic [2*HALF_W-1:0]   out_jc_result;
    logic                  in_jc_ready;
    logic                  out_jc_timeout;
    logic [COUNT_W-1:0]    out_jc_count;

    modport slave (
        input  in_jc_lo_valid, in_jc_lo_data,
        input  in_jc_hi_valid, in_jc_hi_data,
        input  in_jc_ready,
        output out_jc_lo_ready, out_jc_hi_ready,
        output out_jc_valid, out_jc_result,
        output out_jc_timeout, out_jc_count
    );

    modport master (
        output in_jc_lo_valid, in_jc_lo_data,
        output in_jc_hi_valid, in_jc_hi_data,
        output in_jc_ready,
        input  out_jc_lo_ready, out_jc_hi_ready,
        input  out_jc_valid, out_jc_result,
        input  out_jc_timeout, out_jc_count
    );

endinterface

// File: rtl/join_branch_slot.sv
// One branch holding slot: captures a payload on valid && ready and keeps it
// until the join logic clears it.
//   in_jc_clk/in_jc_rst : clock, synchronous active-high reset
//   in_valid/in_data    : branch payload offer
//   in_clear            : drop the held payload (handoff or timeout)
//   out_ready           : slot empty, payload would be taken
//   out_accept          : payload taken this cycle
//   out_data            : held payload
module join_branch_slot #(
    parameter int HALF_W = 4
) (
    input  logic              in_jc_clk,
    input  logic              in_jc_rst,
    input  logic              in_valid,
    input  logic [HALF_W-1:0] in_data,
    input  logic              in_clear,
    output logic              out_ready,
    output logic              out_accept,
    output logic [HALF_W-1:0] out_data
);

    logic              full_reg;
    logic [HALF_W-1:0] data_reg;

    assign out_ready  = !full_reg;
    assign out_accept = in_valid && !full_reg;
    assign out_data   = data_reg;

    always_ff @(posedge in_jc_clk) begin
        if (in_jc_rst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (in_clear) begin
            full_reg <= 1'b0;
        end else if (out_accept) begin
            full_reg <= 1'b1;
            data_reg <= in_data;
        end
    end

endmodule

// File: rtl/module_join_collector.sv
// Joins a lo and a hi branch payload, arriving in any order, into one word
// {hi, lo} presented on a valid/ready output. A half-finished join is dropped
// after TIMEOUT cycles of waiting (TIMEOUT = 0 waits forever).
//   in_jc_clk/in_jc_rst : clock, synchronous active-high reset
//   jc                  : branch inputs, result output, timeout pulse, join count
module module_join_collector
    import module_join_collector_pkg::*;
#(
    parameter int HALF_W  = DEF_HALF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    in_jc_clk,
    input  logic                    in_jc_rst,
    module_join_collector_if.slave  jc
);

    localparam int LO    = 0;
    localparam int HI    = 1;
    localparam int CNT_W = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] EXPIRE_AT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_WAIT_LO = WAIT_LO;
    localparam logic [1:0] ST_WAIT_HI = WAIT_HI;
    localparam logic [1:0] ST_FULL    = FULL;

    logic [1:0]          state_reg, state_next;
    logic [CNT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [2*HALF_W-1:0] result_reg, result_next;
    logic                timeout_reg, timeout_next;
    logic [COUNT_W-1:0]  count_reg, count_next;

    logic [1:0]          br_valid, br_accept, br_clear, br_ready;
    logic [HALF_W-1:0]   br_in_data [2];
    logic [HALF_W-1:0]   br_data    [2];
    logic [HALF_W-1:0]   join_half  [2];
    logic                expire;

    assign br_valid       = {jc.in_jc_hi_valid, jc.in_jc_lo_valid};
    assign br_in_data[LO] = jc.in_jc_lo_data;
    assign br_in_data[HI] = jc.in_jc_hi_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            join_branch_slot #(.HALF_W(HALF_W)) u_slot (
                .in_jc_clk  (in_jc_clk),
                .in_jc_rst  (in_jc_rst),
                .in_valid   (br_valid[gi]),
                .in_data    (br_in_data[gi]),
                .in_clear   (br_clear[gi]),
                .out_ready  (br_ready[gi]),
                .out_accept (br_accept[gi]),
                .out_data   (br_data[gi])
            );
            // A half arriving on the completing cycle is not in its slot yet.
            assign join_half[gi] = br_accept[gi] ? br_in_data[gi] : br_data[gi];
        end
    endgenerate

    // An arrival on the expiry cycle takes priority, so expiry is only acted
    // on when the missing branch was not accepted.
    assign expire = (TIMEOUT != 0) && (wait_cnt_reg == EXPIRE_AT);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        result_next   = result_reg;
        timeout_next  = 1'b0;
        count_next    = count_reg;
        br_clear      = '0;
        case (state_reg)
            ST_IDLE: begin
                if (&br_accept) begin
                    state_next = ST_FULL;
                end else if (br_accept[LO]) begin
                    state_next    = ST_WAIT_HI;
                    wait_cnt_next = '0;
                end else if (br_accept[HI]) begin
                    state_next    = ST_WAIT_LO;
                    wait_cnt_next = '0;
                end
            end
            ST_WAIT_HI: begin
                if (br_accept[HI]) begin
                    state_next = ST_FULL;
                end else if (expire) begin
                    state_next   = ST_IDLE;
                    br_clear[LO] = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (br_accept[LO]) begin
                    state_next = ST_FULL;
                end else if (expire) begin
                    state_next   = ST_IDLE;
                    br_clear[HI] = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: begin
                if (jc.in_jc_ready) begin
                    state_next = ST_IDLE;
                    br_clear   = '1;
                    count_next = count_reg + 1'b1;
                end
            end
        endcase
        // The output word is captured only on entry to FULL so it stays put
        // while the consumer stalls and after the handoff.
        if (state_next == ST_FULL && state_reg != ST_FULL) begin
            result_next = {join_half[HI], join_half[LO]};
        end
    end

    always_ff @(posedge in_jc_clk) begin
        if (in_jc_rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            result_reg   <= '0;
            timeout_reg  <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            result_reg   <= result_next;
            timeout_reg  <= timeout_next;
            count_reg    <= count_next;
        end
    end

    assign jc.out_jc_lo_ready = br_ready[LO];
    assign jc.out_jc_hi_ready = br_ready[HI];
    assign jc.out_jc_valid    = (state_reg == ST_FULL);
    assign jc.out_jc_result   = result_reg;
    assign jc.out_jc_timeout  = timeout_reg;
    assign jc.out_jc_count    = count_reg;

endmodule

// File: tb/tb_module_join_collector.sv
module tb_module_join_collector;
    import module_join_collector_pkg::*;

    localparam int HW = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    module_join_collector_if #(.HALF_W(HW)) jc_if ();
    module_join_collector_if #(.HALF_W(HW)) jz_if ();

    module_join_collector #(.HALF_W(HW), .TIMEOUT(TO)) dut (
        .in_jc_clk (clk),
        .in_jc_rst (rst),
        .jc        (jc_if)
    );

    module_join_collector #(.HALF_W(HW), .TIMEOUT(0)) dut_z (
        .in_jc_clk (clk),
        .in_jc_rst (rst),
        .jc        (jz_if)
    );

    typedef struct {
        bit         is_to;
        logic [7:0] res;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: which halves are held, their values, how long the
    // partial join has waited, and how many joins were handed off.
    bit       m_lo_held, m_hi_held;
    logic [3:0] m_lo_val, m_hi_val;
    int       m_age;
    int       m_joins;

    task automatic step(input bit lv, input logic [3:0] ld, input bit hv,
                        input logic [3:0] hd, input bit rdy);
        bit   acc_lo, acc_hi, was;
        exp_t e;
        @(posedge clk); #1;
        n_vec++;
        if (jc_if.out_jc_lo_ready !== !m_lo_held) begin
            n_err++;
            $display("FAIL lo_ready: got %b, required %b", jc_if.out_jc_lo_ready, !m_lo_held);
        end
        n_vec++;
        if (jc_if.out_jc_hi_ready !== !m_hi_held) begin
            n_err++;
            $display("FAIL hi_ready: got %b, required %b", jc_if.out_jc_hi_ready, !m_hi_held);
        end
        jc_if.in_jc_lo_valid = lv;
        jc_if.in_jc_lo_data  = ld;
        jc_if.in_jc_hi_valid = hv;
        jc_if.in_jc_hi_data  = hd;
        jc_if.in_jc_ready    = rdy;
        acc_lo = lv && !m_lo_held;
        acc_hi = hv && !m_hi_held;
        if (m_lo_held && m_hi_held) begin
            if (rdy) begin
                m_lo_held = 0;
                m_hi_held = 0;
                m_joins++;
            end
        end else begin
            was = m_lo_held || m_hi_held;
            if (acc_lo) begin m_lo_held = 1; m_lo_val = ld; end
            if (acc_hi) begin m_hi_held = 1; m_hi_val = hd; end
            if (m_lo_held && m_hi_held) begin
                e.is_to = 0; e.res = {m_hi_val, m_lo_val}; e.cnt = 8'(m_joins);
                exp_q.push_back(e);
            end else if (m_lo_held || m_hi_held) begin
                if (!was) m_age = 0;
                else begin
                    m_age++;
                    if (m_age == TO) begin
                        m_lo_held = 0;
                        m_hi_held = 0;
                        e.is_to = 1; e.res = '0; e.cnt = '0;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        jc_if.in_jc_lo_valid = 0; jc_if.in_jc_hi_valid = 0; jc_if.in_jc_ready = 0;
        @(posedge clk); #1;
        exp_q.delete();
        m_lo_held = 0; m_hi_held = 0; m_age = 0; m_joins = 0;
        chk8("rst_valid",   {7'd0, jc_if.out_jc_valid},   8'h00);
        chk8("rst_result",  jc_if.out_jc_result,          8'h00);
        chk8("rst_timeout", {7'd0, jc_if.out_jc_timeout}, 8'h00);
        chk8("rst_count",   jc_if.out_jc_count,           8'h00);
        rst = 1'b0;
    endtask

    // Monitor: compare whatever the DUT presents against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (jc_if.out_jc_timeout !== 1'b0) begin
                    n_vec++;
                    if (exp_q.size() == 0 || !exp_q[0].is_to) begin
                        n_err++;
                        $display("FAIL timeout_pulse: got %b, required 0", jc_if.out_jc_timeout);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
                if (jc_if.out_jc_valid !== 1'b0) begin
                    n_vec++;
                    if (exp_q.size() == 0 || exp_q[0].is_to) begin
                        n_err++;
                        $display("FAIL valid_unexpected: got valid=%b result=%h, required valid=0",
                                 jc_if.out_jc_valid, jc_if.out_jc_result);
                    end else begin
                        if (jc_if.out_jc_result !== exp_q[0].res) begin
                            n_err++;
                            $display("FAIL result: got %h, required %h", jc_if.out_jc_result, exp_q[0].res);
                        end
                        if (jc_if.in_jc_ready) begin
                            n_vec++;
                            if (jc_if.out_jc_count !== exp_q[0].cnt) begin
                                n_err++;
                                $display("FAIL count_at_handoff: got %0d, required %0d",
                                         jc_if.out_jc_count, exp_q[0].cnt);
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit seen_pulse;
        jc_if.in_jc_lo_valid = 0; jc_if.in_jc_lo_data = '0;
        jc_if.in_jc_hi_valid = 0; jc_if.in_jc_hi_data = '0;
        jc_if.in_jc_ready    = 0;
        jz_if.in_jc_lo_valid = 0; jz_if.in_jc_lo_data = '0;
        jz_if.in_jc_hi_valid = 0; jz_if.in_jc_hi_data = '0;
        jz_if.in_jc_ready    = 0;
        m_lo_val = '0; m_hi_val = '0;
        do_reset();

        // lo first, hi two cycles later, consumer ready
        step(1, 4'hF, 0, 4'h0, 1);
        step(0, 4'h0, 0, 4'h0, 1);
        step(0, 4'h0, 1, 4'hA, 1);
        step(0, 4'h0, 0, 4'h0, 1);
        step(0, 4'h0, 0, 4'h0, 1);
        chk8("count_after_first", jc_if.out_jc_count, 8'(m_joins));

        // both halves in one cycle, consumer stalls with lo still offered
        step(1, 4'h3, 1, 4'hC, 0);
        repeat (5) step(1, 4'h6, 0, 4'h0, 0);
        step(0, 4'h0, 0, 4'h0, 1);
        step(0, 4'h0, 0, 4'h0, 1);

        // hi alone: expires after TO waiting cycles
        step(0, 4'h0, 1, 4'h5, 0);
        repeat (TO + 3) step(0, 4'h0, 0, 4'h0, 0);
        chk8("count_after_timeout", jc_if.out_jc_count, 8'(m_joins));

        // lo arriving on the expiry cycle completes the join instead
        step(0, 4'h0, 1, 4'h5, 0);
        repeat (TO - 1) step(0, 4'h0, 0, 4'h0, 0);
        step(1, 4'h9, 0, 4'h0, 0);
        step(0, 4'h0, 0, 4'h0, 1);
        step(0, 4'h0, 0, 4'h0, 1);

        // reset while waiting and while holding a result
        step(1, 4'h2, 0, 4'h0, 0);
        do_reset();
        step(1, 4'h4, 1, 4'h8, 0);
        step(0, 4'h0, 0, 4'h0, 0);
        do_reset();

        // back-to-back joins to wrap the counter
        repeat (512) step(1, 4'($urandom_range(0, 15)), 1, 4'($urandom_range(0, 15)), 1);
        step(0, 4'h0, 0, 4'h0, 1);
        chk8("count_wrap", jc_if.out_jc_count, 8'h00);
        chk8("count_wrap_model", jc_if.out_jc_count, 8'(m_joins));

        // dense random traffic, then sparse traffic that exercises timeouts
        repeat (2000)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        repeat (2000)
            step(($urandom % 25) == 0, 4'($urandom_range(0, 15)),
                 ($urandom % 25) == 0, 4'($urandom_range(0, 15)),
                 ($urandom % 3) != 0);
        repeat (TO + 4) step(0, 4'h0, 0, 4'h0, 1);
        chk8("count_final", jc_if.out_jc_count, 8'(m_joins));
        chk8("queue_drained", 8'(exp_q.size()), 8'h00);

        // TIMEOUT=0 instance: a lone lo half waits indefinitely
        @(posedge clk); #1;
        jz_if.in_jc_lo_valid = 1; jz_if.in_jc_lo_data = 4'h7;
        @(posedge clk); #1;
        jz_if.in_jc_lo_valid = 0;
        seen_pulse = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (jz_if.out_jc_timeout !== 1'b0) seen_pulse = 1;
        end
        chk8("nt_pulse",    {7'd0, seen_pulse},             8'h00);
        chk8("nt_lo_ready", {7'd0, jz_if.out_jc_lo_ready},  8'h00);
        chk8("nt_hi_ready", {7'd0, jz_if.out_jc_hi_ready},  8'h01);
        jz_if.in_jc_hi_valid = 1; jz_if.in_jc_hi_data = 4'h2; jz_if.in_jc_ready = 1;
        @(posedge clk); #1;
        jz_if.in_jc_hi_valid = 0;
        chk8("nt_valid",  {7'd0, jz_if.out_jc_valid}, 8'h01);
        chk8("nt_result", jz_if.out_jc_result,        8'h27);
        @(posedge clk); #1;
        chk8("nt_count",  jz_if.out_jc_count,         8'h01);
        chk8("nt_idle",   {7'd0, jz_if.out_jc_valid}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
